// File: rtl/mem_responder.sv
// Word-organised RAM with a fixed-latency read channel (req/busy/valid) and a
// never-stalling byte-enabled write channel; flags misaligned/out-of-range accesses.
module mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned RD_LATENCY  = 1,
   parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        rd_req_i,
   input  logic [31:0] rd_addr_i,
   output logic        rd_busy_o,
   output logic        rd_valid_o,
   output logic [31:0] rd_data_o,
   input  logic        wr_enable_i,
   input  logic [31:0] wr_addr_i,
   input  logic [31:0] wr_data_i,
   input  logic [3:0]  wr_be_i,
   output logic        err_o
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1);
   localparam logic [32:0] SPAN  = 33'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   logic [31:0]      mem [DEPTH_WORDS];
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      rd_addr_q;

   logic             accept_c;
   logic             load_resp_c;
   logic [31:0]      rd_sel_c;
   logic             rd_ok_c;
   logic             wr_ok_c;
   logic [IDX_W-1:0] rd_idx_c;
   logic [IDX_W-1:0] wr_idx_c;
   logic             wr_hit_c;
   logic [31:0]      rd_merged_c;

   // Offset is computed one bit wider so addresses below BASE_ADDR go negative
   function automatic logic addr_ok(input logic [31:0] a);
      logic [32:0] off;
      off = {1'b0, a} - {1'b0, BASE_ADDR};
      return (a[1:0] == 2'b00) && !off[32] && (off < SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return IDX_W'(off >> 2);
   endfunction

   assign rd_busy_o   = (state == WAIT);
   assign accept_c    = rd_req_i && (state != WAIT);
   assign load_resp_c = (RD_LATENCY == 1) ? accept_c : ((state == WAIT) && (cnt == '0));
   assign rd_sel_c    = (state == WAIT) ? rd_addr_q : rd_addr_i;
   assign rd_ok_c     = addr_ok(rd_sel_c);
   assign wr_ok_c     = addr_ok(wr_addr_i);
   assign rd_idx_c    = addr_idx(rd_sel_c);
   assign wr_idx_c    = addr_idx(wr_addr_i);
   assign wr_hit_c    = wr_enable_i && wr_ok_c;

   // Forward same-cycle write lanes into the response
   always_comb begin
      rd_merged_c = mem[rd_idx_c];
      for (int k = 0; k < 4; k++) begin
         if (wr_hit_c && (wr_idx_c == rd_idx_c) && wr_be_i[k]) begin
            rd_merged_c[8*k +: 8] = wr_data_i[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i && wr_hit_c) begin
         for (int k = 0; k < 4; k++) begin
            if (wr_be_i[k]) begin
               mem[wr_idx_c][8*k +: 8] <= wr_data_i[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state      <= IDLE;
         cnt        <= '0;
         rd_addr_q  <= '0;
         rd_valid_o <= 1'b0;
         rd_data_o  <= '0;
         err_o      <= 1'b0;
      end else begin
         rd_valid_o <= load_resp_c;
         err_o      <= (load_resp_c && !rd_ok_c) || (wr_enable_i && !wr_ok_c);
         if (load_resp_c) begin
            rd_data_o <= rd_ok_c ? rd_merged_c : ERR_DATA;
         end
         case (state)
            IDLE, RESP: begin
               if (accept_c) begin
                  rd_addr_q <= rd_addr_i;
                  if (RD_LATENCY == 1) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_W'(RD_LATENCY - 2);
                  end
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances at read latencies 1, 2 and 3.
module tb_mem_responder;

   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   typedef struct {
      int          dut;
      int          due;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   exp_t        sb [$];

   logic        rst   [3];
   logic        req   [3];
   logic [31:0] raddr [3];
   logic        busy  [3];
   logic        valid [3];
   logic [31:0] rdata [3];
   logic        we    [3];
   logic [31:0] waddr [3];
   logic [31:0] wdata [3];
   logic [3:0]  wbe   [3];
   logic        err   [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_responder #(
         .DEPTH_WORDS(1024),
         .BASE_ADDR  (32'h0),
         .RD_LATENCY (g + 1),
         .ERR_DATA   (ERR)
      ) u_dut (
         .clk_i      (clk),
         .reset_i    (rst[g]),
         .rd_req_i   (req[g]),
         .rd_addr_i  (raddr[g]),
         .rd_busy_o  (busy[g]),
         .rd_valid_o (valid[g]),
         .rd_data_o  (rdata[g]),
         .wr_enable_i(we[g]),
         .wr_addr_i  (waddr[g]),
         .wr_data_i  (wdata[g]),
         .wr_be_i    (wbe[g]),
         .err_o      (err[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input int d, input int due, input logic [31:0] data, input logic e);
      exp_t x;
      x.dut = d; x.due = due; x.data = data; x.err = e;
      sb.push_back(x);
   endtask

   task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v, input logic [3:0] be);
      we[d] = 1'b1; waddr[d] = a; wdata[d] = v; wbe[d] = be;
      tick();
      we[d] = 1'b0;
   endtask

   // Issue a read from idle and let it drain
   task automatic rd(input int d, input logic [31:0] a, input logic [31:0] v, input logic e);
      req[d] = 1'b1; raddr[d] = a;
      push(d, cyc + d + 1, v, e);
      tick();
      req[d] = 1'b0;
      repeat (d + 1) tick();
   endtask

   // Responses are matched in order per instance
   always @(negedge clk) begin
      int idx;
      for (int d = 0; d < 3; d++) begin
         if (valid[d] === 1'b1) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
               if (sb[i].dut == d) begin
                  idx = i;
                  break;
               end
            end
            if (idx < 0) begin
               check($sformatf("d%0d_spurious_valid", d), 32'(valid[d]), 32'd0);
            end else begin
               check($sformatf("d%0d_due", d), 32'(cyc), 32'(sb[idx].due));
               check($sformatf("d%0d_data", d), rdata[d], sb[idx].data);
               check($sformatf("d%0d_err", d), 32'(err[d]), 32'(sb[idx].err));
               sb.delete(idx);
            end
         end
      end
   end

   initial begin
      int k;
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b0; req[d] = 1'b0; raddr[d] = '0;
         we[d] = 1'b0; waddr[d] = '0; wdata[d] = '0; wbe[d] = '0;
      end
      repeat (2) tick();
      for (int d = 0; d < 3; d++) begin
         check($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 32'd0);
         check($sformatf("d%0d_rst_valid", d), 32'(valid[d]), 32'd0);
         check($sformatf("d%0d_rst_data", d), rdata[d], 32'd0);
         check($sformatf("d%0d_rst_err", d), 32'(err[d]), 32'd0);
         rst[d] = 1'b1;
      end
      tick();

      // Latency 1: basic read, byte lanes, data hold
      wr(0, 32'h10, 32'h1122_3344, 4'b1111);
      rd(0, 32'h10, 32'h1122_3344, 1'b0);
      tick();
      check("l1_hold_data", rdata[0], 32'h1122_3344);
      check("l1_hold_valid", 32'(valid[0]), 32'd0);
      wr(0, 32'h10, 32'hAABB_CCDD, 4'b0101);
      rd(0, 32'h10, 32'h11BB_33DD, 1'b0);

      // Latency 1: back-to-back reads, second forwarded from a same-cycle write
      wr(0, 32'h14, 32'hCAFE_F00D, 4'b1111);
      req[0] = 1'b1; raddr[0] = 32'h10;
      push(0, cyc + 1, 32'h11BB_33DD, 1'b0);
      tick();
      raddr[0] = 32'h14;
      we[0] = 1'b1; waddr[0] = 32'h14; wdata[0] = 32'h5500_0000; wbe[0] = 4'b1000;
      push(0, cyc + 1, 32'h55FE_F00D, 1'b0);
      tick();
      check("l1_b2b_busy", 32'(busy[0]), 32'd0);
      req[0] = 1'b0; we[0] = 1'b0;
      tick();

      // Boundary words, then error handling
      wr(0, 32'hFFC, 32'h1357_9BDF, 4'b1111);
      wr(0, 32'h0, 32'h0102_0304, 4'b1111);
      rd(0, 32'hFFC, 32'h1357_9BDF, 1'b0);
      rd(0, 32'h12, ERR, 1'b1);
      rd(0, 32'h1000, ERR, 1'b1);
      wr(0, 32'h1000, 32'hFFFF_FFFF, 4'b1111);
      check("wr_oob_err", 32'(err[0]), 32'd1);
      tick();
      check("wr_oob_err_clear", 32'(err[0]), 32'd0);
      wr(0, 32'h11, 32'hFFFF_FFFF, 4'b1111);
      check("wr_misalign_err", 32'(err[0]), 32'd1);
      wr(0, 32'h10, 32'hFFFF_FFFF, 4'b0000);
      check("wr_be0_no_err", 32'(err[0]), 32'd0);
      rd(0, 32'h0, 32'h0102_0304, 1'b0);
      rd(0, 32'h10, 32'h11BB_33DD, 1'b0);
      req[0] = 1'b1; raddr[0] = 32'h1000;
      we[0] = 1'b1; waddr[0] = 32'h2; wdata[0] = 32'h0; wbe[0] = 4'b1111;
      push(0, cyc + 1, ERR, 1'b1);
      tick();
      req[0] = 1'b0; we[0] = 1'b0;
      tick();
      check("dual_err_single_pulse", 32'(err[0]), 32'd0);

      // Latency 3: held request, busy window, second acceptance in RESP
      wr(2, 32'h10, 32'h1122_3344, 4'b1111);
      wr(2, 32'h14, 32'h0BAD_F00D, 4'b1111);
      k = cyc;
      req[2] = 1'b1; raddr[2] = 32'h10;
      push(2, k + 3, 32'h1122_3344, 1'b0);
      tick();
      raddr[2] = 32'h14;
      check("l3_busy_t1", 32'(busy[2]), 32'd1);
      tick();
      check("l3_busy_t2", 32'(busy[2]), 32'd1);
      tick();
      check("l3_busy_t3", 32'(busy[2]), 32'd0);
      push(2, cyc + 3, 32'h0BAD_F00D, 1'b0);
      tick();
      req[2] = 1'b0;
      check("l3_busy_t4", 32'(busy[2]), 32'd1);
      repeat (4) tick();
      check("l3_idle_valid", 32'(valid[2]), 32'd0);

      // Latency 2: forwarding from a write in the cycle after acceptance
      wr(1, 32'h20, 32'h0, 4'b1111);
      wr(1, 32'h24, 32'h0, 4'b1111);
      req[1] = 1'b1; raddr[1] = 32'h20;
      push(1, cyc + 2, 32'h0000_00FF, 1'b0);
      tick();
      req[1] = 1'b0;
      we[1] = 1'b1; waddr[1] = 32'h20; wdata[1] = 32'h0000_00FF; wbe[1] = 4'b0001;
      tick();
      we[1] = 1'b0;
      tick();
      req[1] = 1'b1; raddr[1] = 32'h20;
      push(1, cyc + 2, 32'h0000_00FF, 1'b0);
      tick();
      req[1] = 1'b0;
      we[1] = 1'b1; waddr[1] = 32'h24; wdata[1] = 32'h0000_0077; wbe[1] = 4'b1111;
      tick();
      we[1] = 1'b0;
      tick();
      rd(1, 32'h24, 32'h0000_0077, 1'b0);

      // Latency 3: reset while waiting discards the read and blocks writes
      req[2] = 1'b1; raddr[2] = 32'h10;
      tick();
      req[2] = 1'b0; rst[2] = 1'b0;
      we[2] = 1'b1; waddr[2] = 32'h10; wdata[2] = 32'hFFFF_FFFF; wbe[2] = 4'b1111;
      tick();
      rst[2] = 1'b1; we[2] = 1'b0;
      check("rst_wait_busy", 32'(busy[2]), 32'd0);
      check("rst_wait_valid", 32'(valid[2]), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rst_wait_novalid%0d", i), 32'(valid[2]), 32'd0);
      end
      rd(2, 32'h10, 32'h1122_3344, 1'b0);

      // Reset in RESP, then acceptance in the first released cycle
      req[2] = 1'b1; raddr[2] = 32'h14;
      push(2, cyc + 3, 32'h0BAD_F00D, 1'b0);
      tick();
      raddr[2] = 32'h10;
      repeat (2) tick();
      rst[2] = 1'b0;
      tick();
      check("rst_resp_data", rdata[2], 32'd0);
      check("rst_resp_busy", 32'(busy[2]), 32'd0);
      rst[2] = 1'b1;
      push(2, cyc + 3, 32'h1122_3344, 1'b0);
      tick();
      req[2] = 1'b0;
      repeat (5) tick();

      check("pending_responses", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
